riscv_io_sequencer: RTL

- Synthesizable, parametrised stimulus/check sequencer for the RV32I cache SoC. It replaces the fixed reset-then-wait bench flow with a programmable step table.
- Holds the DUT in reset for a set number of cycles, then releases it. For each step it drives a switch value and waits until a selected DUT output channel matches an expected value for a required number of consecutive cycles.
- Reports pass, or the first failing step with its cause.
- Sits between the cache SoC IO ports and the bench, or an on-board LED/hex status.

---
 rtl/riscv_io_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/riscv_io_sequencer.sv
// Programmable reset/stimulus/check sequencer for the RV32I cache SoC.
// Holds the DUT in reset, then for each step drives a switch word and waits for a masked channel match.
module riscv_io_sequencer #(
    parameter int WIDTH         = 32,
    parameter int NUM_CH        = 8,
    parameter int NUM_STEPS     = 4,
    parameter int RST_CYCLES    = 10,
    parameter int STABLE_CYCLES = 3,
    parameter int TIMEOUT       = 200,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int STEP_W       = $clog2(NUM_STEPS) + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [NUM_STEPS*WIDTH-1:0]  step_sw_i,
    input  logic [NUM_STEPS*WIDTH-1:0]  step_exp_i,
    input  logic [NUM_STEPS*WIDTH-1:0]  step_mask_i,
    input  logic [NUM_STEPS*CH_W-1:0]   step_ch_i,
    input  logic [NUM_CH*WIDTH-1:0]     ch_data_i,
    output logic                        dut_rst_no,
    output logic [WIDTH-1:0]            io_sw_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        pass_o,
    output logic [STEP_W-1:0]           fail_step_o,
    output logic [1:0]                  fail_code_o,
    output logic [31:0]                 cycle_cnt_o
);

    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_BAD_CH  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD_RST, S_APPLY, S_WAIT, S_PASS, S_FAIL
    } state_t;

    state_t              state, state_nxt;
    logic [STEP_W-1:0]   step;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [STAB_W-1:0]   stable_cnt, stable_nxt;
    logic [TO_W-1:0]     timeout_cnt, timeout_nxt;

    logic [WIDTH-1:0]    cur_sw, cur_exp, cur_mask, sel_data;
    logic [CH_W-1:0]     cur_ch;
    logic                ch_bad, match, stable_hit, timeout_hit, last_step, hold_last;

    // Decode the current step entry and evaluate its channel compare.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        sel_data = '0;
        cur_sw   = step_sw_i[int'(step)*WIDTH +: WIDTH];
        cur_exp  = step_exp_i[int'(step)*WIDTH +: WIDTH];
        cur_mask = step_mask_i[int'(step)*WIDTH +: WIDTH];
        cur_ch   = step_ch_i[int'(step)*CH_W +: CH_W];
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cur_ch) == i) sel_data = ch_data_i[i*WIDTH +: WIDTH];
        end
        ch_bad      = int'(cur_ch) >= NUM_CH;
        match       = ((sel_data ^ cur_exp) & cur_mask) == '0;
        stable_nxt  = match ? stable_cnt + STAB_W'(1) : '0;
        timeout_nxt = timeout_cnt + TO_W'(1);
        stable_hit  = stable_nxt == STAB_W'(STABLE_CYCLES);
        timeout_hit = timeout_nxt == TO_W'(TIMEOUT);
        last_step   = step == STEP_W'(NUM_STEPS - 1);
        hold_last   = hold_cnt == HOLD_W'(RST_CYCLES - 1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_PASS, S_FAIL: if (start_i) state_nxt = S_HOLD_RST;
            S_HOLD_RST:             if (hold_last) state_nxt = S_APPLY;
            S_APPLY:                state_nxt = ch_bad ? S_FAIL : S_WAIT;
            S_WAIT: begin
                // An accepted step takes priority over a timeout on the same cycle.
                if (stable_hit)       state_nxt = last_step ? S_PASS : S_APPLY;
                else if (timeout_hit) state_nxt = S_FAIL;
            end
            default:                state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state == S_HOLD_RST) || (state == S_APPLY) || (state == S_WAIT);
        done_o     = (state == S_PASS) || (state == S_FAIL);
        pass_o     = state == S_PASS;
        dut_rst_no = (state == S_APPLY) || (state == S_WAIT) || done_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            step        <= '0;
            hold_cnt    <= '0;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
            io_sw_o     <= '0;
            fail_step_o <= '1;
            fail_code_o <= CODE_NONE;
            cycle_cnt_o <= '0;
        end else begin
            case (state)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (start_i) begin
                        step        <= '0;
                        hold_cnt    <= '0;
                        fail_step_o <= '1;
                        fail_code_o <= CODE_NONE;
                        cycle_cnt_o <= '0;
                    end
                end
                S_HOLD_RST: hold_cnt <= hold_cnt + HOLD_W'(1);
                S_APPLY: begin
                    io_sw_o     <= cur_sw;
                    stable_cnt  <= '0;
                    timeout_cnt <= '0;
                    if (cycle_cnt_o != '1) cycle_cnt_o <= cycle_cnt_o + 32'd1;
                    if (ch_bad) begin
                        fail_step_o <= step;
                        fail_code_o <= CODE_BAD_CH;
                    end
                end
                S_WAIT: begin
                    stable_cnt  <= stable_nxt;
                    timeout_cnt <= timeout_nxt;
                    if (cycle_cnt_o != '1) cycle_cnt_o <= cycle_cnt_o + 32'd1;
                    if (stable_hit) begin
                        if (!last_step) step <= step + STEP_W'(1);
                    end else if (timeout_hit) begin
                        fail_step_o <= step;
                        fail_code_o <= CODE_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
